// File: rtl/mold_pkg.sv
// Shared MoldUDP64 definitions: field widths, the parser beat record and
// the assembler state encoding.
package mold_pkg;

    localparam int AXI_DATA_W = 64;             // parser beat width in bits
    localparam int AXI_KEEP_W = AXI_DATA_W / 8; // byte-mask width
    localparam int LEN        = 20;             // MoldUDP64 header length in bytes
    localparam int ML_W       = 16;             // message-length field width
    localparam int MH_W       = 8 * LEN;        // MoldUDP64 header width in bits
    localparam int SID_W      = 80;             // session id width
    localparam int SEQ_W      = 64;             // sequence number width
    localparam int MAX_MSG_B  = 64;             // assembled message buffer in bytes

    // One beat as produced by the MoldUDP64 parser.
    typedef struct packed {
        logic                  v;
        logic                  start;
        logic [ML_W-1:0]       len;
        logic [AXI_KEEP_W-1:0] mask;
        logic [AXI_DATA_W-1:0] data;
    } mold_msg_t;

    // DONE means the work buffer holds a finished message that is handed
    // to the output register during that cycle.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } asm_state_e;

endpackage

// File: rtl/mold_byte_placer.sv
// Places the valid lanes of one beat at byte offset cnt of the message
// buffer. Purely combinational; lanes landing at or past the buffer end
// produce no write enable.
module mold_byte_placer #(
    parameter int AXI_KEEP_W = 8,
    parameter int CNT_W      = 16,
    parameter int MAX_MSG_B  = 64
) (
    input  logic [AXI_KEEP_W-1:0]   mask,
    input  logic [8*AXI_KEEP_W-1:0] data,
    input  logic [CNT_W-1:0]        cnt,
    output logic [MAX_MSG_B-1:0]    wr_en,
    output logic [8*MAX_MSG_B-1:0]  wr_data
);

    // Each buffer byte k takes lane i when that lane is valid and cnt+i == k.
    always_comb begin
        wr_en   = '0;
        wr_data = '0;
        for (int k = 0; k < MAX_MSG_B; k++) begin
            for (int i = 0; i < AXI_KEEP_W; i++) begin
                if (mask[i] && (int'(cnt) + i == k)) begin
                    wr_en[k]         = 1'b1;
                    wr_data[8*k +: 8] = data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/mold_msg_assembler.sv
// Reassembles multi-beat MoldUDP64 messages into one flat buffer and
// presents each whole message on a valid/ready output register.
//
// Output handshake: a message transfers on every clock edge where
// msg_v_o and msg_ready_i are both 1. While msg_v_o=1 and msg_ready_i=0
// all msg_* outputs hold. The upstream beat stream has no backpressure,
// so a message completing against a full output is dropped (overrun_o).
module mold_msg_assembler
    import mold_pkg::asm_state_e, mold_pkg::IDLE, mold_pkg::COLLECT, mold_pkg::DONE;
#(
    parameter int AXI_DATA_W = mold_pkg::AXI_DATA_W,
    parameter int AXI_KEEP_W = AXI_DATA_W / 8,
    parameter int ML_W       = mold_pkg::ML_W,
    parameter int MAX_MSG_B  = mold_pkg::MAX_MSG_B
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   mold_msg_v_i,
    input  logic                   mold_msg_start_i,
    input  logic [ML_W-1:0]        mold_msg_len_i,
    input  logic [AXI_KEEP_W-1:0]  mold_msg_mask_i,
    input  logic [AXI_DATA_W-1:0]  mold_msg_data_i,
    output logic                   msg_v_o,
    input  logic                   msg_ready_i,
    output logic [ML_W-1:0]        msg_len_o,
    output logic [8*MAX_MSG_B-1:0] msg_data_o,
    output logic                   msg_err_o,
    output logic                   overrun_o,
    output asm_state_e             dbg_state
);

    localparam int BUF_W = 8 * MAX_MSG_B;

    asm_state_e            state, state_nxt;
    logic [ML_W-1:0]       cnt, work_len;
    logic                  work_err;
    logic [BUF_W-1:0]      work_buf, buf_nxt;

    logic                  accept_new, cont, update, comp, comp_err;
    logic [ML_W-1:0]       base_cnt, len_eff, cnt_nxt;
    logic [ML_W:0]         n_bytes, cnt_sum;
    logic [AXI_KEEP_W-1:0] eff_mask;
    logic [MAX_MSG_B-1:0]  wr_en;
    logic [BUF_W-1:0]      wr_data;

    assign dbg_state = state;

    // Beat decode: which message the beat belongs to, byte count and the
    // lanes that still fall inside the declared length.
    always_comb begin
        accept_new = mold_msg_v_i & mold_msg_start_i;
        cont       = mold_msg_v_i & ~mold_msg_start_i & (state == COLLECT);
        update     = accept_new | cont;
        base_cnt   = accept_new ? '0 : cnt;
        len_eff    = accept_new ? mold_msg_len_i : work_len;
        n_bytes    = '0;
        eff_mask   = '0;
        for (int i = 0; i < AXI_KEEP_W; i++) begin
            n_bytes = n_bytes + {{ML_W{1'b0}}, mold_msg_mask_i[i]};
            eff_mask[i] = mold_msg_mask_i[i] &&
                          (({1'b0, base_cnt} + (ML_W+1)'(i)) < {1'b0, len_eff});
        end
        cnt_sum = {1'b0, base_cnt} + n_bytes;
        cnt_nxt = cnt_sum[ML_W] ? '1 : cnt_sum[ML_W-1:0];
        // A start beat inside COLLECT cuts the old message short.
        comp     = (state == DONE) | ((state == COLLECT) & accept_new);
        comp_err = (state == COLLECT) | work_err;
    end

    mold_byte_placer #(
        .AXI_KEEP_W (AXI_KEEP_W),
        .CNT_W      (ML_W),
        .MAX_MSG_B  (MAX_MSG_B)
    ) u_placer (
        .mask    (eff_mask),
        .data    (mold_msg_data_i),
        .cnt     (base_cnt),
        .wr_en   (wr_en),
        .wr_data (wr_data)
    );

    // Next work buffer: a start beat clears it before the new bytes land.
    always_comb begin
        buf_nxt = work_buf;
        for (int k = 0; k < MAX_MSG_B; k++) begin
            if (wr_en[k]) begin
                buf_nxt[8*k +: 8] = wr_data[8*k +: 8];
            end else if (accept_new) begin
                buf_nxt[8*k +: 8] = 8'h00;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: any accepted beat re-evaluates completion; DONE lasts one cycle.
    always_comb begin
        state_nxt = state;
        if (update) begin
            state_nxt = (cnt_nxt >= len_eff) ? DONE : COLLECT;
        end else if (state == DONE) begin
            state_nxt = IDLE;
        end
    end

    // Work buffer, byte counter, length and error flag of the message being built.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            work_buf <= '0;
            cnt      <= '0;
            work_len <= '0;
            work_err <= 1'b0;
        end else if (update) begin
            work_buf <= buf_nxt;
            cnt      <= cnt_nxt;
            if (accept_new) begin
                work_len <= mold_msg_len_i;
                work_err <= (mold_msg_len_i == '0) ||
                            (32'(mold_msg_len_i) > 32'(MAX_MSG_B));
            end
        end
    end

    // Output register: load on completion when free or draining, else drop and flag overrun.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            msg_v_o    <= 1'b0;
            msg_len_o  <= '0;
            msg_data_o <= '0;
            msg_err_o  <= 1'b0;
            overrun_o  <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (comp) begin
                if (!msg_v_o || msg_ready_i) begin
                    msg_v_o    <= 1'b1;
                    msg_len_o  <= work_len;
                    msg_data_o <= work_buf;
                    msg_err_o  <= comp_err;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (msg_v_o && msg_ready_i) begin
                msg_v_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mold_msg_assembler.sv
// Directed bench for mold_msg_assembler: a vector table for single-step
// behaviour plus hand sequences for reset, backpressure, oversize and
// back-to-back traffic.
module tb_mold_msg_assembler;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam int MW = 16;
    localparam int MB = 64;

    typedef struct {
        mold_pkg::mold_msg_t beat;
        logic                ready;
        logic                exp_v;
        logic [MW-1:0]       exp_len;
        logic                exp_err;
        logic [8*MB-1:0]     exp_data;
        logic [1:0]          exp_state;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            nreset;
    logic            mold_msg_v_i, mold_msg_start_i;
    logic [MW-1:0]   mold_msg_len_i;
    logic [KW-1:0]   mold_msg_mask_i;
    logic [DW-1:0]   mold_msg_data_i;
    logic            msg_v_o, msg_ready_i, msg_err_o, overrun_o;
    logic [MW-1:0]   msg_len_o;
    logic [8*MB-1:0] msg_data_o;
    mold_pkg::asm_state_e dbg_state;

    always #5 clk = ~clk;

    mold_msg_assembler dut (
        .clk              (clk),
        .nreset           (nreset),
        .mold_msg_v_i     (mold_msg_v_i),
        .mold_msg_start_i (mold_msg_start_i),
        .mold_msg_len_i   (mold_msg_len_i),
        .mold_msg_mask_i  (mold_msg_mask_i),
        .mold_msg_data_i  (mold_msg_data_i),
        .msg_v_o          (msg_v_o),
        .msg_ready_i      (msg_ready_i),
        .msg_len_o        (msg_len_o),
        .msg_data_o       (msg_data_o),
        .msg_err_o        (msg_err_o),
        .overrun_o        (overrun_o),
        .dbg_state        (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[$];
    logic [8*MB-1:0] exp_q[$];

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_COLL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // ---------------- helpers ----------------
    function automatic logic [8*MB-1:0] mk(input logic [7:0] base, input int n);
        logic [8*MB-1:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = base + 8'(k);
        return r;
    endfunction

    function automatic logic [DW-1:0] beat_bytes(input logic [7:0] base);
        logic [DW-1:0] r;
        for (int i = 0; i < KW; i++) r[8*i +: 8] = base + 8'(i);
        return r;
    endfunction

    function automatic mold_pkg::mold_msg_t bt(input logic v, input logic s, input logic [MW-1:0] len,
                                               input logic [KW-1:0] mask, input logic [DW-1:0] data);
        mold_pkg::mold_msg_t b;
        b.v = v; b.start = s; b.len = len; b.mask = mask; b.data = data;
        return b;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input mold_pkg::mold_msg_t b, input logic rdy);
        mold_msg_v_i     = b.v;
        mold_msg_start_i = b.start;
        mold_msg_len_i   = b.len;
        mold_msg_mask_i  = b.mask;
        mold_msg_data_i  = b.data;
        msg_ready_i      = rdy;
    endtask

    task automatic idle(input logic rdy);
        apply(bt(1'b0, 1'b0, '0, '0, '0), rdy);
    endtask

    task automatic add_vec(input mold_pkg::mold_msg_t b, input logic rdy, input logic ev,
                           input logic [MW-1:0] el, input logic ee, input logic [8*MB-1:0] ed,
                           input logic [1:0] es);
        vec_t t;
        t.beat = b; t.ready = rdy; t.exp_v = ev; t.exp_len = el;
        t.exp_err = ee; t.exp_data = ed; t.exp_state = es;
        vecs.push_back(t);
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [8*MB-1:0] act, input logic [8*MB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic ev, input logic [MW-1:0] el,
                             input logic ee, input logic eo, input logic [8*MB-1:0] ed,
                             input logic [1:0] es);
        chk({name, ".msg_v"}, 512'(msg_v_o), 512'(ev));
        chk({name, ".overrun"}, 512'(overrun_o), 512'(eo));
        chk({name, ".state"}, 512'(dbg_state), 512'(es));
        if (ev) begin
            chk({name, ".len"}, 512'(msg_len_o), 512'(el));
            chk({name, ".err"}, 512'(msg_err_o), 512'(ee));
            chk({name, ".data"}, msg_data_o, ed);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, ".msg_v"}, 512'(msg_v_o), '0);
        chk({name, ".len"}, 512'(msg_len_o), '0);
        chk({name, ".data"}, msg_data_o, '0);
        chk({name, ".err"}, 512'(msg_err_o), '0);
        chk({name, ".overrun"}, 512'(overrun_o), '0);
        chk({name, ".state"}, 512'(dbg_state), 512'(S_IDLE));
    endtask

    // Pops one expected message for every valid output cycle (ready held high).
    task automatic sb_sample(input string name);
        if (msg_v_o) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL %s: unexpected message len %0d", name, msg_len_o);
            end else begin
                logic [8*MB-1:0] e;
                e = exp_q.pop_front();
                if (msg_data_o !== e) begin
                    n_errors++;
                    $display("FAIL %s: got %0h expected %0h", name, msg_data_o, e);
                end
            end
        end
    endtask

    // ---------------- test ----------------
    initial begin
        idle(1'b1);
        nreset = 1'b0;

        // Reset held 2 clk during live traffic.
        for (int c = 0; c < 2; c++) begin
            apply(bt(1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 40)),
                     8'hFF >> $urandom_range(0, 7), {$urandom, $urandom}), 1'b1);
            tick();
        end
        check_reset_outputs("rst_init");
        nreset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            apply(bt(1'b1, 1'b0, 16'd8, 8'hFF, {$urandom, $urandom}), 1'b1);
            tick();
            check_out($sformatf("rst_nostart%0d", c), 1'b0, '0, 1'b0, 1'b0, '0, S_IDLE);
        end

        // Reset in the middle of a message discards it.
        apply(bt(1'b1, 1'b1, 16'd20, 8'hFF, beat_bytes(8'h01)), 1'b1);
        tick();
        check_out("rst_mid_pre", 1'b0, '0, 1'b0, 1'b0, '0, S_COLL);
        nreset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            apply(bt(1'b1, 1'b0, 16'd20, 8'hFF, beat_bytes(8'h09)), 1'b1);
            tick();
        end
        check_reset_outputs("rst_mid");
        nreset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            apply(bt(1'b1, 1'b0, 16'd20, 8'hFF, beat_bytes(8'h11)), 1'b1);
            tick();
            check_out($sformatf("rst_mid_after%0d", c), 1'b0, '0, 1'b0, 1'b0, '0, S_IDLE);
        end

        // Reset while a message is held at the output clears it.
        apply(bt(1'b1, 1'b1, 16'd1, 8'h01, 64'h77), 1'b0);
        tick();
        idle(1'b0);
        tick();
        check_out("rst_hold_pre", 1'b1, 16'd1, 1'b0, 1'b0, 512'h77, S_IDLE);
        nreset = 1'b0;
        tick();
        check_reset_outputs("rst_hold");
        nreset = 1'b1;

        // Vector table: one beat per step, outputs compared after the edge.
        add_vec(bt(1, 1, 16'd6, 8'h3F, 64'h0000_6655_4433_2211), 1, 0, '0, 0, '0, S_DONE);
        add_vec(bt(0, 0, '0, '0, '0), 1, 1, 16'd6, 0, 512'h6655_4433_2211, S_IDLE);
        add_vec(bt(1, 1, 16'd20, 8'hFF, beat_bytes(8'h01)), 1, 0, '0, 0, '0, S_COLL);
        add_vec(bt(1, 0, 16'd0, 8'hFF, beat_bytes(8'h09)), 1, 0, '0, 0, '0, S_COLL);
        add_vec(bt(1, 0, 16'd0, 8'h0F, 64'hAAAA_AAAA_1413_1211), 1, 0, '0, 0, '0, S_DONE);
        add_vec(bt(0, 0, '0, '0, '0), 1, 1, 16'd20, 0, mk(8'h01, 20), S_IDLE);
        add_vec(bt(0, 0, '0, '0, '0), 1, 0, '0, 0, '0, S_IDLE);
        add_vec(bt(1, 1, 16'd20, 8'hFF, beat_bytes(8'h21)), 1, 0, '0, 0, '0, S_COLL);
        add_vec(bt(1, 1, 16'd2, 8'h0F, 64'hDEAD_BEEF_CAFE_3231), 1, 1, 16'd20, 1, mk(8'h21, 8), S_DONE);
        add_vec(bt(0, 0, '0, '0, '0), 1, 1, 16'd2, 0, 512'h3231, S_IDLE);
        add_vec(bt(0, 0, '0, '0, '0), 1, 0, '0, 0, '0, S_IDLE);
        add_vec(bt(1, 0, 16'd4, 8'hFF, 64'h1234_5678_9ABC_DEF0), 1, 0, '0, 0, '0, S_IDLE);
        add_vec(bt(1, 1, 16'd0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF), 1, 0, '0, 0, '0, S_DONE);
        add_vec(bt(0, 0, '0, '0, '0), 1, 1, 16'd0, 1, '0, S_IDLE);
        add_vec(bt(0, 0, '0, '0, '0), 1, 0, '0, 0, '0, S_IDLE);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].beat, vecs[i].ready);
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_len, vecs[i].exp_err,
                      1'b0, vecs[i].exp_data, vecs[i].exp_state);
        end

        // Backpressure: A held, B dropped with overrun, then C replaces A on a handshake.
        apply(bt(1, 1, 16'd3, 8'h07, 64'h00C3_C2C1), 1'b0);
        tick();
        idle(1'b0);
        tick();
        check_out("bp_a", 1, 16'd3, 0, 0, 512'hC3_C2C1, S_IDLE);
        apply(bt(1, 1, 16'd2, 8'h03, 64'hB2B1), 1'b0);
        tick();
        check_out("bp_b_beat", 1, 16'd3, 0, 0, 512'hC3_C2C1, S_DONE);
        idle(1'b0);
        tick();
        check_out("bp_overrun", 1, 16'd3, 0, 1, 512'hC3_C2C1, S_IDLE);
        tick();
        check_out("bp_after", 1, 16'd3, 0, 0, 512'hC3_C2C1, S_IDLE);
        apply(bt(1, 1, 16'd2, 8'h03, 64'hD2D1), 1'b0);
        tick();
        check_out("bp_c_beat", 1, 16'd3, 0, 0, 512'hC3_C2C1, S_DONE);
        idle(1'b1);
        tick();
        check_out("bp_replace", 1, 16'd2, 0, 0, 512'hD2D1, S_IDLE);
        tick();
        check_out("bp_drain", 0, '0, 0, 0, '0, S_IDLE);

        // Oversize: len=100 over 13 beats, only the first 64 bytes kept.
        for (int j = 0; j < 13; j++) begin
            apply(bt(1, (j == 0), 16'd100, 8'hFF, beat_bytes(8'(8 * j))), 1'b1);
            tick();
            if (j == 0)  check_out("big_first", 0, '0, 0, 0, '0, S_COLL);
            if (j == 11) check_out("big_beat11", 0, '0, 0, 0, '0, S_COLL);
        end
        check_out("big_last", 0, '0, 0, 0, '0, S_DONE);
        idle(1'b1);
        tick();
        check_out("big_msg", 1, 16'd100, 1, 0, mk(8'h00, 64), S_IDLE);
        tick();
        check_out("big_drain", 0, '0, 0, 0, '0, S_IDLE);

        // Back-to-back start beats with ready high: one message per clock.
        for (int j = 0; j < 3; j++) begin
            exp_q.push_back(mk(8'(8'h40 + 8'(16 * j)), 8));
            apply(bt(1, 1, 16'd8, 8'hFF, beat_bytes(8'(8'h40 + 8'(16 * j)))), 1'b1);
            tick();
            sb_sample($sformatf("b2b_beat%0d", j));
        end
        idle(1'b1);
        for (int c = 0; c < 5 && exp_q.size() > 0; c++) begin
            tick();
            sb_sample($sformatf("b2b_idle%0d", c));
        end
        chk("b2b_pending", 512'(exp_q.size()), '0);
        tick();
        check_out("b2b_drain", 0, '0, 0, 0, '0, S_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
